regfile_gen: RTL and testbench

REGFILE_GEN -- requirements
Module: regfile_gen

---
 rtl/regfile_gen.sv | 126 ++++++++++++
 tb/tb_regfile_gen.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_gen.sv
// regfile_gen: small register file with protected addresses, a synchronized
// input port at address 1 and a sticky poll-event flag at address DEPTH-1.
// Reads are combinational with write-through bypass; Rout mirrors the stored
// accumulator register.
`timescale 1ns/1ps
module regfile_gen #(
  parameter int n       = 8,
  parameter int DEPTH   = 8,
  parameter int ACC_IDX = 6,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          n_reset,
  input  logic          w,
  input  logic [AW-1:0] Waddr,
  input  logic [n-1:0]  Wdata,
  input  logic [AW-1:0] Raddr1,
  input  logic [AW-1:0] Raddr2,
  input  logic          poll,
  input  logic          poll_clr,
  input  logic [n-1:0]  inport,
  output logic [n-1:0]  Rdata1,
  output logic [n-1:0]  Rdata2,
  output logic [n-1:0]  Rout,
  output logic          poll_flag
);

  // Addresses 0, 1 and DEPTH-1 have no storage behind them.
  function automatic logic is_gpr(input logic [AW-1:0] a);
    return (a >= AW'(2)) && (a <= AW'(DEPTH - 2));
  endfunction

  logic [n-1:0]  gpr_r [DEPTH];
  logic [n-1:0]  in_s1_r;
  logic [n-1:0]  in_s2_r;
  logic          poll_s1_r;
  logic          poll_s2_r;
  logic          poll_d_r;
  logic          poll_flag_r;
  logic          poll_flag_nxt_s;
  logic          poll_rise_s;
  logic          wr_ok_s;
  logic [AW-1:0] raddr_s [2];
  logic [n-1:0]  rdata_s [2];

  assign wr_ok_s     = w && is_gpr(Waddr);
  assign poll_rise_s = poll_s2_r && !poll_d_r;
  assign raddr_s[0]  = Raddr1;
  assign raddr_s[1]  = Raddr2;

  // Register storage: cleared on reset, written only where storage exists
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        gpr_r[i] <= '0;
      end
    end else if (wr_ok_s) begin
      gpr_r[Waddr] <= Wdata;
    end
  end

  // Two-flop synchronizers for inport and poll, plus the poll edge-detect flop
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      in_s1_r   <= '0;
      in_s2_r   <= '0;
      poll_s1_r <= 1'b0;
      poll_s2_r <= 1'b0;
      poll_d_r  <= 1'b0;
    end else begin
      in_s1_r   <= inport;
      in_s2_r   <= in_s1_r;
      poll_s1_r <= poll;
      poll_s2_r <= poll_s1_r;
      poll_d_r  <= poll_s2_r;
    end
  end

  // Sticky flag next state: a fresh synchronized rising edge beats a clear
  always_comb begin
    poll_flag_nxt_s = poll_flag_r;
    if (poll_rise_s) begin
      poll_flag_nxt_s = 1'b1;
    end else if (poll_clr) begin
      poll_flag_nxt_s = 1'b0;
    end else begin
      poll_flag_nxt_s = poll_flag_r;
    end
  end

  // Poll flag register
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      poll_flag_r <= 1'b0;
    end else begin
      poll_flag_r <= poll_flag_nxt_s;
    end
  end

  // Read decode for both ports; bypass is suppressed while reset is held so
  // every address reads zero during reset.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rdata_s[p] = '0;
      if (!n_reset) begin
        rdata_s[p] = '0;
      end else if (wr_ok_s && (Waddr == raddr_s[p])) begin
        rdata_s[p] = Wdata;
      end else if (raddr_s[p] == AW'(0)) begin
        rdata_s[p] = '0;
      end else if (raddr_s[p] == AW'(1)) begin
        rdata_s[p] = in_s2_r;
      end else if (raddr_s[p] == AW'(DEPTH - 1)) begin
        rdata_s[p] = {{(n-1){1'b0}}, poll_flag_r};
      end else begin
        rdata_s[p] = gpr_r[raddr_s[p]];
      end
    end
  end

  assign Rdata1    = rdata_s[0];
  assign Rdata2    = rdata_s[1];
  assign Rout      = gpr_r[ACC_IDX];
  assign poll_flag = poll_flag_r;

endmodule

// File: tb/tb_regfile_gen.sv
// Self-checking bench for regfile_gen: directed scenarios plus a randomized
// run, all compared against a history-based reference model.
`timescale 1ns/1ps
module tb_regfile_gen;
  localparam int N   = 8;
  localparam int D   = 8;
  localparam int ACC = 6;
  localparam int AW  = 3;

  logic          clk = 1'b0;
  logic          n_reset;
  logic          w;
  logic [AW-1:0] Waddr;
  logic [N-1:0]  Wdata;
  logic [AW-1:0] Raddr1;
  logic [AW-1:0] Raddr2;
  logic          poll;
  logic          poll_clr;
  logic [N-1:0]  inport;
  logic [N-1:0]  Rdata1;
  logic [N-1:0]  Rdata2;
  logic [N-1:0]  Rout;
  logic          poll_flag;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state
  logic [N-1:0] m_gpr [D];
  logic [N-1:0] m_in;
  logic         m_flag;
  logic [N-1:0] ih [$];
  bit           ph [$];

  regfile_gen #(.n(N), .DEPTH(D), .ACC_IDX(ACC)) dut (
    .clk(clk), .n_reset(n_reset), .w(w), .Waddr(Waddr), .Wdata(Wdata),
    .Raddr1(Raddr1), .Raddr2(Raddr2), .poll(poll), .poll_clr(poll_clr),
    .inport(inport), .Rdata1(Rdata1), .Rdata2(Rdata2), .Rout(Rout),
    .poll_flag(poll_flag)
  );

  always #5 clk = ~clk;

  function automatic void model_reset();
    for (int i = 0; i < D; i++) m_gpr[i] = '0;
    m_in   = '0;
    m_flag = 1'b0;
    ih = {8'h00, 8'h00};
    ph = {1'b0, 1'b0, 1'b0};
  endfunction

  // Expected combinational read for the current inputs and model state
  function automatic logic [N-1:0] exp_rd(input logic [AW-1:0] a);
    logic [N-1:0] r;
    if (!n_reset) r = '0;
    else if (w && a == Waddr && Waddr >= 2 && Waddr <= D - 2) r = Wdata;
    else if (a == 0) r = '0;
    else if (a == 1) r = m_in;
    else if (a == D - 1) r = {7'b0, m_flag};
    else r = m_gpr[a];
    return r;
  endfunction

  // One clock: update the model from the inputs sampled at the rising edge
  task automatic step();
    bit rise;
    @(posedge clk);
    if (n_reset) begin
      // synchronized poll seen at this edge is the sample from two edges ago,
      // the previously seen one is from three edges ago
      rise = ph[ph.size()-2] && !ph[ph.size()-3];
      if (rise) m_flag = 1'b1;
      else if (poll_clr) m_flag = 1'b0;
      ph.push_back(poll);
      if (ph.size() > 4) void'(ph.pop_front());
      ih.push_back(inport);
      if (ih.size() > 3) void'(ih.pop_front());
      m_in = ih[ih.size()-2];
      if (w && Waddr >= 2 && Waddr <= D - 2) m_gpr[Waddr] = Wdata;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    n_reset = 1'b0; w = 1'b1; Waddr = 3'd3; Wdata = 8'h55;
    Raddr1 = 3'd3; Raddr2 = 3'd7; poll = 1'b0; poll_clr = 1'b0; inport = 8'h00;
    model_reset();
    #12;
    n_checks++;
    if (Rdata1 !== 8'h00) $display("FAIL reset_read: Rdata1=%h expected 00", Rdata1);
    else n_pass++;
    n_checks++;
    if (Rout !== 8'h00 || poll_flag !== 1'b0)
      $display("FAIL reset_outs: Rout=%h poll_flag=%b expected 00/0", Rout, poll_flag);
    else n_pass++;
    step();
    n_reset = 1'b1; w = 1'b0;
    #1;
    n_checks++;
    if (Rdata1 !== 8'h00) $display("FAIL reset_discard: Rdata1=%h expected 00", Rdata1);
    else n_pass++;
    w = 1'b1; Wdata = 8'h12;
    step();
    w = 1'b0;
    #1;
    n_checks++;
    if (Rdata1 !== 8'h12) $display("FAIL first_write: Rdata1=%h expected 12", Rdata1);
    else n_pass++;
  endtask

  task automatic test_reset_mid_write();
    w = 1'b1; Waddr = 3'd6; Wdata = 8'hA5; Raddr1 = 3'd6;
    step();
    w = 1'b0;
    #1;
    n_checks++;
    if (Rout !== 8'hA5) $display("FAIL midrst_pre: Rout=%h expected a5", Rout);
    else n_pass++;
    #1 n_reset = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if (Rout !== 8'h00) $display("FAIL midrst_rout: Rout=%h expected 00", Rout);
    else n_pass++;
    @(posedge clk); @(negedge clk);
    n_reset = 1'b1;
    #1;
    n_checks++;
    if (Rdata1 !== 8'h00) $display("FAIL midrst_read: Rdata1=%h expected 00", Rdata1);
    else n_pass++;
  endtask

  task automatic test_basic();
    w = 1'b1; Waddr = 3'd4; Wdata = 8'h3C; Raddr1 = 3'd4; Raddr2 = 3'd2;
    #1;
    n_checks++;
    if (Rdata1 !== 8'h3C) $display("FAIL basic_bypass: Rdata1=%h expected 3c", Rdata1);
    else n_pass++;
    step();
    w = 1'b0; Raddr2 = 3'd4;
    #1;
    n_checks++;
    if (Rdata1 !== 8'h3C || Rdata2 !== 8'h3C)
      $display("FAIL basic_read: Rdata1=%h Rdata2=%h expected 3c/3c", Rdata1, Rdata2);
    else n_pass++;
  endtask

  task automatic test_protected();
    logic [AW-1:0] pa [3];
    pa[0] = 3'd0; pa[1] = 3'd1; pa[2] = 3'd7;
    inport = 8'h33;
    w = 1'b1; Waddr = 3'd6; Wdata = 8'h77;
    step();
    for (int i = 0; i < 3; i++) begin
      w = 1'b1; Waddr = pa[i]; Wdata = 8'hFF;
      step();
    end
    w = 1'b0;
    for (int i = 0; i < 3; i++) begin
      Raddr1 = pa[i]; Raddr2 = pa[i];
      #1;
      n_checks++;
      if (Rdata1 !== exp_rd(pa[i]) || Rdata2 !== exp_rd(pa[i]))
        $display("FAIL protected_read a=%0d: Rdata1=%h Rdata2=%h expected %h", pa[i], Rdata1, Rdata2, exp_rd(pa[i]));
      else n_pass++;
    end
    n_checks++;
    if (Rout !== 8'h77) $display("FAIL protected_rout: Rout=%h expected 77", Rout);
    else n_pass++;
  endtask

  task automatic test_inport();
    w = 1'b0; Raddr2 = 3'd1; inport = 8'h00;
    step(); step(); step();
    inport = 8'h5A;
    step();
    #1;
    n_checks++;
    if (Rdata2 !== 8'h00) $display("FAIL inport_1cyc: Rdata2=%h expected 00", Rdata2);
    else n_pass++;
    step();
    #1;
    n_checks++;
    if (Rdata2 !== 8'h5A) $display("FAIL inport_2cyc: Rdata2=%h expected 5a", Rdata2);
    else n_pass++;
  endtask

  task automatic test_poll();
    w = 1'b0; poll = 1'b0; poll_clr = 1'b0; Raddr1 = 3'd7;
    step(); step(); step();
    poll = 1'b1;
    step(); step();
    #1;
    n_checks++;
    if (poll_flag !== 1'b0) $display("FAIL poll_early: poll_flag=%b expected 0", poll_flag);
    else n_pass++;
    step();
    #1;
    n_checks++;
    if (poll_flag !== 1'b1 || Rdata1 !== 8'h01)
      $display("FAIL poll_set: poll_flag=%b Rdata1=%h expected 1/01", poll_flag, Rdata1);
    else n_pass++;
    poll_clr = 1'b1;
    step();
    poll_clr = 1'b0;
    step(); step(); step();
    #1;
    n_checks++;
    if (poll_flag !== 1'b0) $display("FAIL poll_held: poll_flag=%b expected 0", poll_flag);
    else n_pass++;
    poll = 1'b0;
    step(); step(); step();
    poll = 1'b1;
    step(); step();
    poll_clr = 1'b1;
    step();
    poll_clr = 1'b0;
    #1;
    n_checks++;
    if (poll_flag !== 1'b1) $display("FAIL poll_set_wins: poll_flag=%b expected 1", poll_flag);
    else n_pass++;
    poll_clr = 1'b1; poll = 1'b0;
    step(); step(); step();
    poll_clr = 1'b0;
    poll = 1'b1;
    step();
    n_reset = 1'b0; poll = 1'b0;
    model_reset();
    @(posedge clk); @(negedge clk);
    n_reset = 1'b1;
    step(); step(); step(); step();
    #1;
    n_checks++;
    if (poll_flag !== 1'b0) $display("FAIL poll_reset_lost: poll_flag=%b expected 0", poll_flag);
    else n_pass++;
  endtask

  task automatic test_acc();
    w = 1'b1; Waddr = ACC[AW-1:0]; Wdata = 8'h10;
    step();
    Wdata = 8'h81; Raddr1 = ACC[AW-1:0];
    #1;
    n_checks++;
    if (Rdata1 !== 8'h81 || Rout !== 8'h10)
      $display("FAIL acc_same_cycle: Rdata1=%h Rout=%h expected 81/10", Rdata1, Rout);
    else n_pass++;
    step();
    w = 1'b0;
    #1;
    n_checks++;
    if (Rout !== 8'h81) $display("FAIL acc_after: Rout=%h expected 81", Rout);
    else n_pass++;
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      w = 1'($urandom_range(0, 1));
      Waddr = 3'($urandom_range(0, 7));
      Wdata = 8'($urandom);
      Raddr1 = 3'($urandom_range(0, 7));
      Raddr2 = ($urandom_range(0, 3) == 0) ? Waddr : 3'($urandom_range(0, 7));
      if ($urandom_range(0, 5) == 0) poll = ~poll;
      poll_clr = ($urandom_range(0, 6) == 0);
      if ($urandom_range(0, 2) == 0) inport = 8'($urandom);
      #1;
      n_checks++;
      if (Rdata1 !== exp_rd(Raddr1) || Rdata2 !== exp_rd(Raddr2))
        $display("FAIL rand_read k=%0d: Rdata1=%h Rdata2=%h expected %h/%h", k, Rdata1, Rdata2, exp_rd(Raddr1), exp_rd(Raddr2));
      else n_pass++;
      n_checks++;
      if (Rout !== m_gpr[ACC] || poll_flag !== m_flag)
        $display("FAIL rand_state k=%0d: Rout=%h poll_flag=%b expected %h/%b", k, Rout, poll_flag, m_gpr[ACC], m_flag);
      else n_pass++;
      step();
    end
  endtask

  initial begin
    test_reset();
    test_reset_mid_write();
    test_basic();
    test_protected();
    test_inport();
    test_poll();
    test_acc();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
